// File: rtl/raiz_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3) for the square-root result.
// Converts one input bit per clock and holds the packed decimal digits until the next conversion.
//
// state | meaning
// IDLE  | waiting for start; bcd holds the last result
// SHIFT | one add-3/shift iteration per clock, EntradaBits iterations
// DONE  | copy scratch digits to bcd and pulse done

module raiz_bcd_converter #(
  parameter int EntradaBits = 16,
  parameter int Digits      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [EntradaBits-1:0]   Raiz,
  output logic                     busy,
  output logic                     done,
  output logic [4*Digits-1:0]      bcd
);

  localparam int CW = $clog2(EntradaBits + 1);
  localparam logic [CW-1:0] LAST = CW'(EntradaBits - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [EntradaBits-1:0] bin_reg;
  logic [4*Digits-1:0]    scratch;
  logic [4*Digits-1:0]    adj;
  logic [CW-1:0]          cnt;

  // Every digit is corrected independently; a digit >= 5 would overflow past 9 after the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < Digits; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bin_reg <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg <= Raiz;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, bin_reg} <= {adj, bin_reg} << 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          bcd   <= scratch;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raiz_bcd_converter.sv
// Directed bench for raiz_bcd_converter: cycle-exact handshake checks plus a result scoreboard.
// Expected digits come from a decimal model; the monitor pops them on each done pulse.

module tb_raiz_bcd_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] Raiz;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  logic [19:0] q[$];
  logic [19:0] exp_hold = '0;

  raiz_bcd_converter #(.EntradaBits(16), .Digits(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Raiz  (Raiz),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: bcd must equal the last popped result except on the done cycle.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (done) begin
        check("done_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) exp_hold = q.pop_front();
        n_done++;
      end
      check("bcd_scoreboard", 32'(bcd), 32'(exp_hold));
      check("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  task automatic run_one(input logic [15:0] v);
    logic [19:0] e;
    e = to_bcd(int'(v));
    @(negedge clk);
    Raiz  = v;
    start = 1'b1;
    q.push_back(e);
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        Raiz  = 16'($urandom);
      end
      check($sformatf("busy_%0d_c%0d", v, c), 32'(busy), 32'(c <= 15));
      check($sformatf("done_%0d_c%0d", v, c), 32'(done), 32'(c == 17));
    end
    check($sformatf("bcd_%0d", v), 32'(bcd), 32'(e));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    reset = 1'b1;
    start = 1'b0;
    Raiz  = '0;

    // reset state, no start
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_bcd", 32'(bcd), 32'd0);
    end

    // single conversions including zero and full-scale
    run_one(16'd11);
    run_one(16'd0);
    run_one(16'd9);
    run_one(16'd10);
    run_one(16'd65535);

    // Raiz change and re-start while busy are both ignored
    d0 = n_done;
    @(negedge clk);
    Raiz  = 16'd255;
    start = 1'b1;
    q.push_back(to_bcd(255));
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == 5) begin
        Raiz  = 16'd1;
        start = 1'b1;
      end
      if (c == 6) start = 1'b0;
      check("ign_busy", 32'(busy), 32'(c <= 15));
      check("ign_done", 32'(done), 32'(c == 17));
    end
    check("ign_bcd", 32'(bcd), 32'h00255);
    repeat (20) @(negedge clk);
    check("ign_done_count", 32'(n_done - d0), 32'd1);
    check("ign_queue_empty", 32'(q.size()), 32'd0);

    // reset in the 8th SHIFT cycle aborts without a done pulse
    d0 = n_done;
    @(negedge clk);
    Raiz  = 16'd4660;
    start = 1'b1;
    q.push_back(to_bcd(4660));
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      check("pre_abort_busy", 32'(busy), 32'd1);
    end
    q.delete();
    exp_hold = '0;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    run_one(16'd4660);

    // start held high: back-to-back conversions every 18 cycles
    d0 = n_done;
    @(negedge clk);
    Raiz  = 16'd100;
    start = 1'b1;
    repeat (3) q.push_back(to_bcd(100));
    for (int c = 0; c <= 53; c++) begin
      @(negedge clk);
      check("b2b_busy", 32'(busy), 32'((c % 18) <= 15));
      check("b2b_done", 32'(done), 32'((c % 18) == 17));
      if ((c % 18) == 17) check("b2b_bcd", 32'(bcd), 32'h00100);
      if (c == 53) start = 1'b0;
    end
    repeat (20) @(negedge clk);
    check("b2b_done_count", 32'(n_done - d0), 32'd3);
    check("final_queue_empty", 32'(q.size()), 32'd0);
    check("final_bcd", 32'(bcd), 32'h00100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
